mem_stall_unit: RTL and testbench
=================================

// Module: mem_stall_unit
// PURPOSE
//  Memory-handshake front end for the 5-stage RV32I pipeline; it generates the stall_pipeline input of the hazard unit.
//  Tracks one outstanding I-side fetch and one D-side load/store against the caches.
//  Holds stall_pipeline high until both ports have completed.
//  A port that finishes early has its result latched and is not re-issued.
// PARAMETERS
//  ADDR_W   32  byte-address width on both memory ports
//  DATA_W   32  data width on both memory ports
//  CNT_W    32  width of the saturating stall-cycle counter
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous reset, active-high
//  if_req        in   1        IF stage requests a fetch this cycle
//  if_addr       in   ADDR_W   fetch address (PC)
//  mem_rd_req    in   1        MEM stage load
//  mem_wr_req    in   1        MEM stage store
//  mem_addr      in   ADDR_W   load/store address
//  mem_wdata     in   DATA_W   store data
//  mem_mbe       in   DATA_W/8 store byte enables
//  imem_read     out  1        I-cache read request
//  imem_address  out  ADDR_W   I-cache address
//  imem_resp     in   1        I-cache done, imem_rdata valid
//  imem_rdata    in   DATA_W   I-cache read data
//  dmem_read     out  1        D-cache read request
//  dmem_write    out  1        D-cache write request
//  dmem_address  out  ADDR_W   D-cache address
//  dmem_wdata    out  DATA_W   D-cache write data
//  dmem_mbe      out  DATA_W/8 D-cache byte enables
//  dmem_resp     in   1        D-cache done
//  dmem_rdata    in   DATA_W   D-cache read data
//  if_rdata      out  DATA_W   instruction to IF/ID register
//  mem_rdata     out  DATA_W   load data to MEM/WB register
//  stall_pipeline out 1        freeze all pipeline registers and PC
//  stall_cycles  out  CNT_W    count of cycles with stall_pipeline=1
// BEHAVIOUR
//  - One identical tracker per port; states IDLE, WAIT, HELD.
//  - pend = (IDLE & req & !resp) | (WAIT & !resp); stall_pipeline = pend_i | pend_d (combinational).
//  - Request strobes are combinational: asserted in IDLE&req and in WAIT, never in HELD, 0 when !req.
//  - IDLE with req: request issues the same cycle; addr/wdata/mbe/rd-wr are captured.
//  - WAIT drives the captured copies; outputs stay stable until resp.
//  - Transitions:
//    - IDLE&req&resp: -> HELD if the other port pends, else stays IDLE (zero-wait hit).
//    - IDLE&req&!resp: -> WAIT.
//    - WAIT&resp: -> HELD if the other port pends, else -> IDLE.
//    - HELD: -> IDLE on the first cycle with stall_pipeline=0.
//  - Entering HELD latches rdata; a HELD write latches nothing.
//  - Data out: rdata = HELD ? latched : cache rdata. Valid in the cycle stall_pipeline falls.
//  - Both resp in the same cycle: both trackers -> IDLE, stall low that cycle, no HELD.
//  - resp while IDLE with no req: ignored.
//  - mem_rd_req & mem_wr_req together: illegal. The read wins and a simulation assertion fires.
//  - Reset: all trackers IDLE, latches 0, stall_cycles 0. All outputs 0 in reset cycles.
//  - Reset mid-WAIT: request drops the next cycle; a late resp is ignored.
//  - stall_cycles: +1 per cycle with stall_pipeline=1; saturates at all-ones, no wrap.
//  - Latency added to a cache hit that responds in the request cycle: 0 cycles.
// STRUCTURE
//  - rv32i_types gains typedef enum logic [1:0] {MP_IDLE, MP_WAIT, MP_HELD} mem_port_state_e.
//  - One sub-module, mem_port_tracker (state, capture regs, data latch, pend), instantiated twice.
//    - D-side instance carries wdata/mbe/write; I-side ties these off.
//  - Top level: pend OR-tree, rdata muxes, stall_cycles counter.
// TESTING
//  1. Both hit in the request cycle -> stall_pipeline stays 0; if_rdata/mem_rdata pass through; stall_cycles=0.
//  2. imem_resp at +2, no D req -> stall 1 for 2 cycles; imem_read stays high until resp; stall_cycles=2.
//  3. imem_resp at +1 (0x00000013), dmem_resp at +4 (0xDEADBEEF):
//     imem_read low after +1; stall falls at +4; if_rdata=0x00000013 from HELD.
//  4. Store 0x12345678, mbe=4'b0011, resp at +3 -> dmem_write with stable addr/wdata/mbe until resp; stall 3 cycles.
//  5. rst in the 2nd WAIT cycle -> imem_read/dmem_read 0 next cycle; a late resp is ignored; counter=0.
//  6. Force stall_cycles to all-ones-1, stall 3 cycles -> reads all-ones, no wrap.

Source files
------------

// File: rtl/mem_stall_unit_pkg.sv
// ============================================================================
// Module   : mem_stall_unit_pkg
// Brief    : Shared types and helpers for the memory-handshake stall unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_stall_unit_pkg;

  typedef enum logic [1:0] {
    MP_IDLE = 2'd0,
    MP_WAIT = 2'd1,
    MP_HELD = 2'd2
  } mem_port_state_e;

  // A port holds the pipeline while its access is issued but not yet answered.
  function automatic logic port_pending(input mem_port_state_e state,
                                        input logic            req,
                                        input logic            resp);
    return ((state == MP_IDLE) && req && !resp) ||
           ((state == MP_WAIT) && !resp);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stall_unit_tracker.sv
// ============================================================================
// Module   : mem_port_tracker
// Brief    : One memory port: IDLE/WAIT/HELD tracker, request capture, data latch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_tracker
  import mem_stall_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] mbe,
  input  logic                resp,
  input  logic [DATA_W-1:0]   cache_rdata,
  input  logic                other_pend,
  output logic                rd_strobe,
  output logic                wr_strobe,
  output logic [ADDR_W-1:0]   addr_out,
  output logic [DATA_W-1:0]   wdata_out,
  output logic [DATA_W/8-1:0] mbe_out,
  output logic                pend,
  output logic [DATA_W-1:0]   rdata
);

  mem_port_state_e     state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] mbe_q, mbe_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mbe_d     = mbe_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    addr_out  = '0;
    wdata_out = '0;
    mbe_out   = '0;
    pend      = port_pending(state_q, req, resp);
    rdata     = (state_q == MP_HELD) ? rdata_q : cache_rdata;

    case (state_q)
      MP_IDLE: begin
        if (req) begin
          rd_strobe = !wr;
          wr_strobe = wr;
          addr_out  = addr;
          wdata_out = wdata;
          mbe_out   = mbe;
          addr_d    = addr;
          wdata_d   = wdata;
          mbe_d     = mbe;
          wr_d      = wr;
          if (!resp) begin
            state_d = MP_WAIT;
          end else if (other_pend) begin
            state_d = MP_HELD;
            if (!wr) rdata_d = cache_rdata;
          end
        end
      end
      MP_WAIT: begin
        rd_strobe = !wr_q;
        wr_strobe = wr_q;
        addr_out  = addr_q;
        wdata_out = wdata_q;
        mbe_out   = mbe_q;
        if (resp) begin
          if (other_pend) begin
            state_d = MP_HELD;
            if (!wr_q) rdata_d = cache_rdata;
          end else begin
            state_d = MP_IDLE;
          end
        end
      end
      MP_HELD: begin
        // Own access is done, so the stall now depends only on the other port.
        if (!other_pend) state_d = MP_IDLE;
      end
      default: state_d = MP_IDLE;
    endcase

    if (rst) begin
      rd_strobe = 1'b0;
      wr_strobe = 1'b0;
      addr_out  = '0;
      wdata_out = '0;
      mbe_out   = '0;
      pend      = 1'b0;
      rdata     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MP_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stall_unit.sv
// ============================================================================
// Module   : mem_stall_unit
// Brief    : I/D memory handshake front end producing the pipeline stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stall_unit
  import mem_stall_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                mem_rd_req,
  input  logic                mem_wr_req,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_mbe,
  output logic                imem_read,
  output logic [ADDR_W-1:0]   imem_address,
  input  logic                imem_resp,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [ADDR_W-1:0]   dmem_address,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_mbe,
  input  logic                dmem_resp,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic [DATA_W-1:0]   if_rdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_pipeline,
  output logic [CNT_W-1:0]    stall_cycles
);

  logic                pend_i, pend_d;
  logic                d_req, d_wr;
  logic                imem_unused_wr;
  logic [DATA_W-1:0]   imem_unused_wdata;
  logic [DATA_W/8-1:0] imem_unused_mbe;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // A simultaneous load and store is resolved as a load.
  assign d_req = mem_rd_req | mem_wr_req;
  assign d_wr  = mem_wr_req & ~mem_rd_req;

  mem_port_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ipath (
    .clk         (clk),
    .rst         (rst),
    .req         (if_req),
    .wr          (1'b0),
    .addr        (if_addr),
    .wdata       ('0),
    .mbe         ('0),
    .resp        (imem_resp),
    .cache_rdata (imem_rdata),
    .other_pend  (pend_d),
    .rd_strobe   (imem_read),
    .wr_strobe   (imem_unused_wr),
    .addr_out    (imem_address),
    .wdata_out   (imem_unused_wdata),
    .mbe_out     (imem_unused_mbe),
    .pend        (pend_i),
    .rdata       (if_rdata)
  );

  mem_port_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dpath (
    .clk         (clk),
    .rst         (rst),
    .req         (d_req),
    .wr          (d_wr),
    .addr        (mem_addr),
    .wdata       (mem_wdata),
    .mbe         (mem_mbe),
    .resp        (dmem_resp),
    .cache_rdata (dmem_rdata),
    .other_pend  (pend_i),
    .rd_strobe   (dmem_read),
    .wr_strobe   (dmem_write),
    .addr_out    (dmem_address),
    .wdata_out   (dmem_wdata),
    .mbe_out     (dmem_mbe),
    .pend        (pend_d),
    .rdata       (mem_rdata)
  );

  always_comb begin
    stall_pipeline = pend_i | pend_d;
    cnt_d          = cnt_q;
    if (stall_pipeline && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    stall_cycles = rst ? '0 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (rst)
                                       !(mem_rd_req && mem_wr_req));

endmodule

`default_nettype wire

// File: tb/tb_mem_stall_unit.sv
// ============================================================================
// Module   : tb_mem_stall_unit
// Brief    : Directed self-checking bench for mem_stall_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stall_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic                mem_rd_req, mem_wr_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_mbe;
  logic                imem_read;
  logic [ADDR_W-1:0]   imem_address;
  logic                imem_resp;
  logic [DATA_W-1:0]   imem_rdata;
  logic                dmem_read, dmem_write;
  logic [ADDR_W-1:0]   dmem_address;
  logic [DATA_W-1:0]   dmem_wdata;
  logic [DATA_W/8-1:0] dmem_mbe;
  logic                dmem_resp;
  logic [DATA_W-1:0]   dmem_rdata;
  logic [DATA_W-1:0]   if_rdata, mem_rdata;
  logic                stall_pipeline;
  logic [CNT_W-1:0]    stall_cycles;

  // Outputs of the narrow-counter instance used for the saturation check.
  logic                s_imem_read, s_dmem_read, s_dmem_write, s_stall;
  logic [ADDR_W-1:0]   s_imem_address, s_dmem_address;
  logic [DATA_W-1:0]   s_dmem_wdata, s_if_rdata, s_mem_rdata;
  logic [DATA_W/8-1:0] s_dmem_mbe;
  logic [1:0]          s_stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stall_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .if_rdata(if_rdata), .mem_rdata(mem_rdata),
    .stall_pipeline(stall_pipeline), .stall_cycles(stall_cycles)
  );

  mem_stall_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe),
    .imem_read(s_imem_read), .imem_address(s_imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_read(s_dmem_read), .dmem_write(s_dmem_write), .dmem_address(s_dmem_address),
    .dmem_wdata(s_dmem_wdata), .dmem_mbe(s_dmem_mbe),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .if_rdata(s_if_rdata), .mem_rdata(s_mem_rdata),
    .stall_pipeline(s_stall), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req     = 1'b0;
    if_addr    = '0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_mbe    = '0;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  // Fetch whose response arrives n cycles after the request (n stall cycles).
  task automatic stall_fetch(input int n);
    if_req  = 1'b1;
    if_addr = 32'h0000_0800;
    for (int i = 0; i <= n; i++) begin
      imem_resp = (i == n);
      tick();
    end
    clear_inputs();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset cycle with live requests: every output must be 0.
    clear_inputs();
    rst        = 1'b1;
    if_req     = 1'b1;
    mem_rd_req = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    @(posedge clk); #1;
    chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
    chk("rst_dmem_read", {31'd0, dmem_read}, 32'd0);
    chk("rst_stall", {31'd0, stall_pipeline}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);

    // 1: both ports hit in the request cycle.
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; imem_resp = 1'b1; imem_rdata = 32'h0050_0093;
    mem_rd_req = 1'b1; mem_addr = 32'h1000; dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("t1_stall", {31'd0, stall_pipeline}, 32'd0);
    chk("t1_imem_read", {31'd0, imem_read}, 32'd1);
    chk("t1_imem_address", imem_address, 32'h40);
    chk("t1_dmem_read", {31'd0, dmem_read}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_mem_rdata", mem_rdata, 32'hCAFE_F00D);
    tick(); clear_inputs(); #1;
    chk("t1_stall_cycles", stall_cycles, 32'd0);

    // 2: fetch answered two cycles after the request.
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("t2_stall_c0", {31'd0, stall_pipeline}, 32'd1);
    tick(); if_addr = 32'h200; #1;
    chk("t2_imem_read_c1", {31'd0, imem_read}, 32'd1);
    chk("t2_imem_address_c1", imem_address, 32'h100);
    chk("t2_stall_c1", {31'd0, stall_pipeline}, 32'd1);
    tick(); imem_resp = 1'b1; imem_rdata = 32'h00A0_0113; #1;
    chk("t2_stall_c2", {31'd0, stall_pipeline}, 32'd0);
    chk("t2_if_rdata", if_rdata, 32'h00A0_0113);
    tick(); clear_inputs(); #1;
    chk("t2_imem_read_after", {31'd0, imem_read}, 32'd0);
    chk("t2_stall_cycles", stall_cycles, 32'd2);

    // 3: I-side done at +1 and held, D-side done at +4.
    do_reset();
    if_req = 1'b1; if_addr = 32'h300; mem_rd_req = 1'b1; mem_addr = 32'h400;
    #1;
    chk("t3_stall_c0", {31'd0, stall_pipeline}, 32'd1);
    tick(); imem_resp = 1'b1; imem_rdata = 32'h0000_0013; #1;
    chk("t3_stall_c1", {31'd0, stall_pipeline}, 32'd1);
    tick(); imem_resp = 1'b0; imem_rdata = 32'hBAD0_BAD0; #1;
    chk("t3_imem_read_c2", {31'd0, imem_read}, 32'd0);
    chk("t3_if_rdata_c2", if_rdata, 32'h0000_0013);
    chk("t3_dmem_address_c2", dmem_address, 32'h400);
    tick(); #1;
    chk("t3_stall_c3", {31'd0, stall_pipeline}, 32'd1);
    tick(); dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk("t3_stall_c4", {31'd0, stall_pipeline}, 32'd0);
    chk("t3_if_rdata_c4", if_rdata, 32'h0000_0013);
    chk("t3_mem_rdata_c4", mem_rdata, 32'hDEAD_BEEF);
    tick(); clear_inputs(); #1;
    chk("t3_stall_cycles", stall_cycles, 32'd4);

    // 4: store answered at +3; captured copies must hold while inputs move.
    do_reset();
    mem_wr_req = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'h1234_5678; mem_mbe = 4'b0011;
    #1;
    chk("t4_dmem_write_c0", {31'd0, dmem_write}, 32'd1);
    chk("t4_dmem_read_c0", {31'd0, dmem_read}, 32'd0);
    tick(); mem_addr = 32'h3000; mem_wdata = 32'h0; mem_mbe = 4'hF; #1;
    chk("t4_dmem_address_c1", dmem_address, 32'h2000);
    chk("t4_dmem_wdata_c1", dmem_wdata, 32'h1234_5678);
    chk("t4_dmem_mbe_c1", {28'd0, dmem_mbe}, 32'h3);
    tick(); #1;
    chk("t4_dmem_wdata_c2", dmem_wdata, 32'h1234_5678);
    chk("t4_stall_c2", {31'd0, stall_pipeline}, 32'd1);
    tick(); dmem_resp = 1'b1; #1;
    chk("t4_dmem_write_c3", {31'd0, dmem_write}, 32'd1);
    chk("t4_stall_c3", {31'd0, stall_pipeline}, 32'd0);
    tick(); clear_inputs(); #1;
    chk("t4_stall_cycles", stall_cycles, 32'd3);

    // 5: reset in the second WAIT cycle, then a late response.
    do_reset();
    if_req = 1'b1; if_addr = 32'h500; mem_rd_req = 1'b1; mem_addr = 32'h600;
    tick(); #1;
    chk("t5_stall_wait1", {31'd0, stall_pipeline}, 32'd1);
    tick(); rst = 1'b1; #1;
    chk("t5_imem_read_rst", {31'd0, imem_read}, 32'd0);
    tick(); rst = 1'b0; clear_inputs(); imem_resp = 1'b1; dmem_resp = 1'b1; #1;
    chk("t5_imem_read_after", {31'd0, imem_read}, 32'd0);
    chk("t5_dmem_read_after", {31'd0, dmem_read}, 32'd0);
    chk("t5_stall_late_resp", {31'd0, stall_pipeline}, 32'd0);
    tick(); clear_inputs(); #1;
    chk("t5_stall_cycles", stall_cycles, 32'd0);
    chk("t5_stall_idle", {31'd0, stall_pipeline}, 32'd0);

    // 6: 2-bit counter brought to all-ones-1, then stalled 3 more cycles.
    do_reset();
    stall_fetch(2);
    chk("t6_sat_pre", {30'd0, s_stall_cycles}, 32'd2);
    stall_fetch(3);
    chk("t6_sat_post", {30'd0, s_stall_cycles}, 32'd3);
    chk("t6_wide_count", stall_cycles, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
